fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of decode.
- Owns the PC register and issues one instruction-bus request at a time using a two-phase addr_ok/data_ok handshake.
- Holds the returned instruction as fetch data (valid, pc, raw_instr) until decode accepts it.
- Handles stall from downstream and PC redirect from execute, including discarding a response that is already in flight.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset.
- PC_STEP, 4, PC increment after each accepted instruction.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- ireq_valid  output  1  instruction-bus request valid.
- ireq_addr  output  64  instruction-bus request address; equals the current PC.
- iresp_addr_ok  input  1  bus accepted the request this cycle.
- iresp_data_ok  input  1  response data valid this cycle.
- iresp_data  input  32  returned instruction word.
- stall  input  1  decode cannot accept fetch data this cycle.
- redirect_valid  input  1  change PC (branch, jump or trap).
- redirect_pc  input  64  new PC.
- dataF_valid  output  1  fetch data valid to decode.
- dataF_pc  output  64  PC of the held instruction.
- dataF_raw_instr  output  32  held instruction word.
- dataF_misalign  output  1  present only with FETCH_MISALIGN_EN.

Behaviour:
- Reset: state=IDLE, pc=RESET_PC, ireq_valid=0, dataF_valid=0, dataF_pc=0, dataF_raw_instr=0. Reset in any state discards any transaction in flight and does no drop tracking; the bus slave shares the same reset.
- States: IDLE, REQ, WAIT, HOLD, DROP.
- IDLE:
  - Always moves to REQ next cycle.
  - A redirect in IDLE loads pc=redirect_pc.
- REQ:
  - ireq_valid=1 and ireq_addr=pc; both stay stable until addr_ok.
  - addr_ok && data_ok in the same cycle: latch the data and go to HOLD.
  - addr_ok only: go to WAIT.
  - Redirect seen in REQ (before or at addr_ok): load pc=redirect_pc. The outstanding request is not withdrawn, because the address must stay stable:
    - If addr_ok has not arrived, keep asserting the old address; on addr_ok go to DROP.
    - If data_ok is in the same cycle as addr_ok, go directly to REQ with the new pc.
    - To support this, an internal req_addr register holds the issued address, separate from pc.
- WAIT:
  - ireq_valid=0.
  - On data_ok: latch iresp_data into raw_instr, then go to HOLD.
  - Redirect in WAIT: load pc=redirect_pc and go to DROP. If data_ok arrives in that same cycle, discard the data and go to REQ instead.
- DROP:
  - ireq_valid=0 and dataF_valid=0.
  - On data_ok: discard the data and go to REQ.
  - A further redirect in DROP overwrites pc; the latest redirect wins.
- HOLD:
  - dataF_valid=1, dataF_pc=req_addr, dataF_raw_instr=latched word.
  - Redirect (takes priority over stall): dataF_valid=0 next cycle, pc=redirect_pc, go to REQ.
  - stall=1: hold all outputs unchanged.
  - stall=0: the instruction is consumed this cycle; pc=pc+PC_STEP (64-bit wrap, no carry out), go to REQ.
- Timing:
  - Best-case throughput is one instruction per 2 cycles (REQ with same-cycle addr_ok/data_ok, then HOLD).
  - dataF_valid is registered and asserted only in HOLD.
- Unexpected inputs: data_ok in IDLE or REQ before addr_ok is a protocol violation and is ignored.

Optional Feature:
- FETCH_MISALIGN_EN defined:
  - Port dataF_misalign exists.
  - If pc[1:0]!=0 when entering REQ, no bus request is issued. The block goes straight to HOLD with raw_instr=0 and dataF_misalign=1.
  - dataF_misalign is 0 in all other cases.
- FETCH_MISALIGN_EN undefined:
  - No port.
  - Address bits [1:0] are passed to the bus unchanged.

Test Plan:
- Reset then bus with same-cycle addr_ok/data_ok, data 32'h00000013 -> first ireq_addr=0x80000000; dataF_valid with pc=0x80000000; next request to 0x80000004.
- stall held 3 cycles in HOLD -> dataF_pc and dataF_raw_instr unchanged, no ireq_valid; release -> next ireq_addr=pc+4.
- addr_ok at cycle 0, redirect to 0x80001000 at cycle 1, data_ok at cycle 3 -> data discarded, dataF_valid stays 0, next ireq_addr=0x80001000.
- redirect while ireq_valid is high and addr_ok is withheld -> ireq_addr stays at the old value until addr_ok; the response is dropped; the following request uses the redirect PC.
- redirect and stall together in HOLD -> redirect wins; dataF_valid=0 next cycle; request issued to redirect_pc.
- FETCH_MISALIGN_EN, redirect to 0x80000002 -> no ireq_valid; dataF_valid=1, dataF_misalign=1, raw_instr=0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage in front of decode.
// Owns the PC, issues one instruction-bus request at a time, and holds the
// returned word for decode until it is consumed or a redirect kills it.
//
// Handshakes:
//   ireq_valid/iresp_addr_ok : a request is transferred on a rising edge where
//     ireq_valid && iresp_addr_ok. While ireq_valid is high without addr_ok,
//     ireq_addr is held stable (a redirect does not withdraw it).
//   iresp_data_ok : one response per accepted request, in the same cycle as
//     addr_ok or any later cycle. data_ok with no accepted request is ignored.
//   dataF_valid/stall : the held instruction is consumed on a rising edge where
//     dataF_valid && !stall && !redirect_valid.
//
// Optional build macro: FETCH_MISALIGN_EN adds dataF_misalign. Misaligned PCs
// then skip the bus and present a zero word flagged as misaligned.
// dbg_state exposes the FSM state for checkers.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        dataF_valid,
    output logic [63:0] dataF_pc,
    output logic [31:0] dataF_raw_instr,
`ifdef FETCH_MISALIGN_EN
    output logic        dataF_misalign,
`endif
    output logic [2:0]  dbg_state
);

    localparam logic [63:0] PC_INC = 64'(PC_STEP);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t      state, state_next;
    logic [63:0] pc, pc_next;
    logic [63:0] req_addr;      // address of the request on the bus, separate from pc
    logic        redir_pend;    // redirect seen in REQ before addr_ok arrived
    logic        pend_next;
    logic        start_req;     // next cycle begins a fresh request at pc_next
    logic        latch_resp;    // capture the bus word as fetch data
    logic        dataF_valid_q;
    logic [63:0] dataF_pc_q;
    logic [31:0] raw_instr_q;
    logic        redirected;    // current request is stale (redirect now or earlier)
`ifdef FETCH_MISALIGN_EN
    logic        misalign_hold; // next cycle holds a misaligned-fetch marker
    logic        misalign_q;
`endif

    assign redirected = redir_pend || redirect_valid;

    // Next-state, next-pc and datapath load enables.
    always_comb begin
        state_next = state;
        pend_next  = redir_pend;
        start_req  = 1'b0;
        latch_resp = 1'b0;
`ifdef FETCH_MISALIGN_EN
        misalign_hold = 1'b0;
`endif
        // Redirect always wins; otherwise the PC only advances on consume.
        if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (state == S_HOLD && !stall) begin
            pc_next = pc + PC_INC;
        end else begin
            pc_next = pc;
        end

        case (state)
            S_IDLE: begin
                state_next = S_REQ;
                start_req  = 1'b1;
            end
            S_REQ: begin
                if (iresp_addr_ok) begin
                    pend_next = 1'b0;
                    if (iresp_data_ok) begin
                        if (redirected) begin
                            state_next = S_REQ;
                            start_req  = 1'b1;
                        end else begin
                            state_next = S_HOLD;
                            latch_resp = 1'b1;
                        end
                    end else begin
                        state_next = redirected ? S_DROP : S_WAIT;
                    end
                end else begin
                    // data_ok before addr_ok is a protocol violation: ignored.
                    pend_next = redirected;
                end
            end
            S_WAIT: begin
                if (iresp_data_ok) begin
                    if (redirect_valid) begin
                        state_next = S_REQ;
                        start_req  = 1'b1;
                    end else begin
                        state_next = S_HOLD;
                        latch_resp = 1'b1;
                    end
                end else if (redirect_valid) begin
                    state_next = S_DROP;
                end
            end
            S_DROP: begin
                if (iresp_data_ok) begin
                    state_next = S_REQ;
                    start_req  = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid || !stall) begin
                    state_next = S_REQ;
                    start_req  = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

`ifdef FETCH_MISALIGN_EN
        // A misaligned PC never reaches the bus; present a flagged bubble word.
        if (start_req && (pc_next[1:0] != 2'b00)) begin
            state_next    = S_HOLD;
            start_req     = 1'b0;
            misalign_hold = 1'b1;
        end
`endif
    end

    // FSM state, PC and request-address registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            redir_pend <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            redir_pend <= pend_next;
            if (start_req) begin
                req_addr <= pc_next;
            end
`ifdef FETCH_MISALIGN_EN
            if (misalign_hold) begin
                req_addr <= pc_next;
            end
`endif
        end
    end

    // Fetch data registers presented to decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            dataF_valid_q <= 1'b0;
            dataF_pc_q    <= 64'h0;
            raw_instr_q   <= 32'h0;
`ifdef FETCH_MISALIGN_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            dataF_valid_q <= (state_next == S_HOLD);
            if (latch_resp) begin
                dataF_pc_q  <= req_addr;
                raw_instr_q <= iresp_data;
`ifdef FETCH_MISALIGN_EN
                misalign_q  <= 1'b0;
`endif
            end
`ifdef FETCH_MISALIGN_EN
            if (misalign_hold) begin
                dataF_pc_q  <= pc_next;
                raw_instr_q <= 32'h0;
                misalign_q  <= 1'b1;
            end
`endif
        end
    end

    assign ireq_valid      = (state == S_REQ);
    assign ireq_addr       = req_addr;
    assign dataF_valid     = dataF_valid_q;
    assign dataF_pc        = dataF_pc_q;
    assign dataF_raw_instr = raw_instr_q;
    assign dbg_state       = state;
`ifdef FETCH_MISALIGN_EN
    assign dataF_misalign  = misalign_q && dataF_valid_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus a randomized run against a
// program-order reference model (next architectural PC and a memory function).
module tb_fetch_stage;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        dataF_valid;
    logic [63:0] dataF_pc;
    logic [31:0] dataF_raw_instr;
`ifdef FETCH_MISALIGN_EN
    logic        dataF_misalign;
`endif
    logic [2:0]  dbg_state;

    int n_cmp;
    int n_fail;

    fetch_stage #(.RESET_PC(RESET_PC), .PC_STEP(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_addr_ok  (iresp_addr_ok),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dataF_valid    (dataF_valid),
        .dataF_pc       (dataF_pc),
        .dataF_raw_instr(dataF_raw_instr),
`ifdef FETCH_MISALIGN_EN
        .dataF_misalign (dataF_misalign),
`endif
        .dbg_state      (dbg_state)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word the memory returns for a given address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ {a[15:0], a[31:16]} ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic idle_inputs();
        iresp_addr_ok  = 1'b0;
        iresp_data_ok  = 1'b0;
        iresp_data     = 32'h0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
    endtask

    // Reset block: two cycles of reset, released on a falling edge.
    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (ireq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ireq_valid: got %b want 0", ireq_valid); end
        n_cmp++; if (dataF_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dataF_valid: got %b want 0", dataF_valid); end
        n_cmp++; if (dataF_pc !== 64'h0) begin n_fail++; $display("FAIL reset_dataF_pc: got %h want 0", dataF_pc); end
        n_cmp++; if (dataF_raw_instr !== 32'h0) begin n_fail++; $display("FAIL reset_raw: got %h want 0", dataF_raw_instr); end
`ifdef FETCH_MISALIGN_EN
        n_cmp++; if (dataF_misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", dataF_misalign); end
`endif
        reset = 1'b0;
    endtask

    // Same-cycle addr_ok/data_ok: best-case two-cycle fetch.
    task automatic test_basic_fetch();
        @(negedge clk);
        n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0000) begin n_fail++; $display("FAIL first_req: got v=%b a=%h want v=1 a=80000000", ireq_valid, ireq_addr); end
        iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h0000_0013;
        @(negedge clk);
        iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0;
        n_cmp++; if (dataF_valid !== 1'b1 || dataF_pc !== 64'h8000_0000 || dataF_raw_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL first_hold: got v=%b pc=%h i=%h want v=1 pc=80000000 i=00000013", dataF_valid, dataF_pc, dataF_raw_instr); end
        n_cmp++; if (ireq_valid !== 1'b0) begin n_fail++; $display("FAIL hold_no_req: got %b want 0", ireq_valid); end
        @(negedge clk);
        n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0004) begin n_fail++; $display("FAIL second_req: got v=%b a=%h want v=1 a=80000004", ireq_valid, ireq_addr); end
    endtask

    // Stall held three cycles in HOLD, then released.
    task automatic test_stall();
        iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h0040_0093;
        @(negedge clk);
        iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (dataF_valid !== 1'b1 || dataF_pc !== 64'h8000_0004 || dataF_raw_instr !== 32'h0040_0093 || ireq_valid !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h i=%h req=%b want v=1 pc=80000004 i=00400093 req=0", i, dataF_valid, dataF_pc, dataF_raw_instr, ireq_valid);
            end
        end
        stall = 1'b0;
        @(negedge clk);
        n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0008 || dataF_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release: got v=%b a=%h fv=%b want v=1 a=80000008 fv=0", ireq_valid, ireq_addr, dataF_valid); end
    endtask

    // Redirect while waiting for data: response discarded.
    task automatic test_redirect_wait();
        iresp_addr_ok = 1'b1;
        @(negedge clk);
        iresp_addr_ok = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_cmp++; if (dataF_valid !== 1'b0 || ireq_valid !== 1'b0) begin n_fail++; $display("FAIL wait_drop: got fv=%b req=%b want 0 0", dataF_valid, ireq_valid); end
        @(negedge clk);
        iresp_data_ok = 1'b1; iresp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        iresp_data_ok = 1'b0;
        n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_1000 || dataF_valid !== 1'b0) begin n_fail++; $display("FAIL wait_redirect_req: got v=%b a=%h fv=%b want v=1 a=80001000 fv=0", ireq_valid, ireq_addr, dataF_valid); end
    endtask

    // Redirect while the request is still waiting for addr_ok.
    task automatic test_redirect_req();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_1000) begin n_fail++; $display("FAIL req_addr_stable[%0d]: got v=%b a=%h want v=1 a=80001000", i, ireq_valid, ireq_addr); end
            if (i == 0) @(negedge clk);
        end
        iresp_addr_ok = 1'b1;
        @(negedge clk);
        iresp_addr_ok = 1'b0;
        n_cmp++; if (ireq_valid !== 1'b0 || dataF_valid !== 1'b0) begin n_fail++; $display("FAIL req_drop: got req=%b fv=%b want 0 0", ireq_valid, dataF_valid); end
        iresp_data_ok = 1'b1; iresp_data = 32'hBAD0_BAD0;
        @(negedge clk);
        iresp_data_ok = 1'b0;
        n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_2000 || dataF_valid !== 1'b0) begin n_fail++; $display("FAIL req_redirect_next: got v=%b a=%h fv=%b want v=1 a=80002000 fv=0", ireq_valid, ireq_addr, dataF_valid); end
    endtask

    // Redirect and stall together in HOLD: redirect wins.
    task automatic test_redirect_stall();
        iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h1111_2222;
        @(negedge clk);
        iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0;
        n_cmp++; if (dataF_valid !== 1'b1 || dataF_pc !== 64'h8000_2000) begin n_fail++; $display("FAIL rs_hold: got v=%b pc=%h want v=1 pc=80002000", dataF_valid, dataF_pc); end
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_3000;
        @(negedge clk);
        stall = 1'b0; redirect_valid = 1'b0;
        n_cmp++; if (dataF_valid !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_3000) begin n_fail++; $display("FAIL rs_redirect: got fv=%b v=%b a=%h want fv=0 v=1 a=80003000", dataF_valid, ireq_valid, ireq_addr); end
    endtask

    // Redirect on the same edge as addr_ok+data_ok, then a stray data_ok.
    task automatic test_back_to_back();
        iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h3333_4444;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_4000;
        @(negedge clk);
        iresp_addr_ok = 1'b0; redirect_valid = 1'b0;
        n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_4000 || dataF_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_redirect: got v=%b a=%h fv=%b want v=1 a=80004000 fv=0", ireq_valid, ireq_addr, dataF_valid); end
        // data_ok still high without addr_ok: must be ignored.
        @(negedge clk);
        iresp_data_ok = 1'b0;
        n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_4000 || dataF_valid !== 1'b0) begin n_fail++; $display("FAIL stray_data_ok: got v=%b a=%h fv=%b want v=1 a=80004000 fv=0", ireq_valid, ireq_addr, dataF_valid); end
    endtask

    // Redirect to a misaligned PC from HOLD.
    task automatic test_misalign();
        iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h5555_6666;
        @(negedge clk);
        iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0002;
        @(negedge clk);
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_EN
        n_cmp++; if (ireq_valid !== 1'b0 || dataF_valid !== 1'b1 || dataF_misalign !== 1'b1 || dataF_raw_instr !== 32'h0 || dataF_pc !== 64'h8000_0002) begin
            n_fail++; $display("FAIL misalign: got req=%b fv=%b m=%b i=%h pc=%h want req=0 fv=1 m=1 i=0 pc=80000002", ireq_valid, dataF_valid, dataF_misalign, dataF_raw_instr, dataF_pc);
        end
`else
        n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0002) begin n_fail++; $display("FAIL misalign_passthru: got v=%b a=%h want v=1 a=80000002", ireq_valid, ireq_addr); end
`endif
    endtask

    // Random bus latency, stalls and redirects against a program-order model.
    task automatic test_random();
        logic [63:0] arch_pc;
        logic [63:0] paddr;
        logic [63:0] prev_addr;
        logic [31:0] exp_word;
        logic        exp_mis;
        logic        pending;
        logic        prev_hold_req;
        int          delay;
        int          consumed;
        do_reset();
        arch_pc       = RESET_PC;
        pending       = 1'b0;
        prev_hold_req = 1'b0;
        prev_addr     = 64'h0;
        paddr         = 64'h0;
        delay         = 0;
        consumed      = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (prev_hold_req) begin
                n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== prev_addr) begin n_fail++; $display("FAIL rnd_addr_stable@%0d: got v=%b a=%h want v=1 a=%h", cyc, ireq_valid, ireq_addr, prev_addr); end
            end
            n_cmp++; if (ireq_valid === 1'b1 && dataF_valid === 1'b1) begin n_fail++; $display("FAIL rnd_req_in_hold@%0d: got req=1 fv=1 want not both", cyc); end
            if (dataF_valid === 1'b1) begin
                exp_word = mem_word(arch_pc);
                exp_mis  = 1'b0;
`ifdef FETCH_MISALIGN_EN
                if (arch_pc[1:0] != 2'b00) begin
                    exp_word = 32'h0;
                    exp_mis  = 1'b1;
                end
                n_cmp++; if (dataF_misalign !== exp_mis) begin n_fail++; $display("FAIL rnd_misalign@%0d: got %b want %b", cyc, dataF_misalign, exp_mis); end
`endif
                n_cmp++; if (dataF_pc !== arch_pc || dataF_raw_instr !== exp_word) begin
                    n_fail++; $display("FAIL rnd_fetch@%0d: got pc=%h i=%h want pc=%h i=%h mis=%b", cyc, dataF_pc, dataF_raw_instr, arch_pc, exp_word, exp_mis);
                end
            end
            // Next-cycle stimulus.
            stall          = ($urandom_range(0, 9) < 3);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = 64'h8000_0000 | 64'($urandom_range(0, 255) << 2);
            if ($urandom_range(0, 7) == 0) redirect_pc = redirect_pc | 64'h2;
            iresp_addr_ok = 1'b0;
            iresp_data_ok = 1'b0;
            iresp_data    = $urandom;
            if (pending) begin
                if (delay == 0) begin
                    iresp_data_ok = 1'b1;
                    iresp_data    = mem_word(paddr);
                    pending       = 1'b0;
                end else begin
                    delay--;
                end
            end else if (ireq_valid === 1'b1 && $urandom_range(0, 1) == 1) begin
                iresp_addr_ok = 1'b1;
                if ($urandom_range(0, 1) == 1) begin
                    iresp_data_ok = 1'b1;
                    iresp_data    = mem_word(ireq_addr);
                end else begin
                    pending = 1'b1;
                    paddr   = ireq_addr;
                    delay   = $urandom_range(0, 3);
                end
            end
            prev_hold_req = (ireq_valid === 1'b1) && !iresp_addr_ok;
            prev_addr     = ireq_addr;
            // Program order: latest redirect wins, otherwise a consume steps the PC.
            if (redirect_valid) begin
                arch_pc = redirect_pc;
            end else if (dataF_valid === 1'b1 && !stall) begin
                arch_pc  = arch_pc + 64'd4;
                consumed++;
            end
        end
        idle_inputs();
        n_cmp++; if (consumed < 100) begin n_fail++; $display("FAIL rnd_progress: got %0d consumed want >= 100", consumed); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        idle_inputs();
        test_reset();
        test_basic_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_req();
        test_redirect_stall();
        test_back_to_back();
        test_misalign();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
